// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state type and boot-stream format constants for the instruction-memory loader
package all_pkgs;
  localparam int WIDTH = 32;
  localparam int IMEM_DEPTH_DEFAULT = 256;
  localparam int BYTE_W = 8;
  localparam int LEN_W = 16;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} loader_state_t;
  function automatic logic rx_state(loader_state_t s);
    return s inside {LEN, DATA, CHK};
  endfunction
endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs little-endian bytes into 32-bit words.
// Ports: clk/rst; clr drops any partial word; en accepts in_data;
// word_valid/word are combinational and valid while the 4th byte is being accepted.
module word_assembler
  import all_pkgs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] in_data,
  output logic              word_valid,
  output logic [WIDTH-1:0]  word
);
  logic [23:0] sh_q, sh_d;
  logic [1:0]  idx_q, idx_d;
  assign word_valid = en && idx_q == 2'd3;
  assign word = {in_data, sh_q};
  always_comb begin
    sh_d  = en ? {in_data, sh_q[23:8]} : sh_q;
    idx_d = clr ? 2'd0 : en ? idx_q + 2'd1 : idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length/words/checksum boot stream and writes it into instruction memory.
// Ports: clk, rst (sync, active-high); start begins a load from IDLE/DONE/ERR;
// in_valid/in_data/in_ready byte stream; imem_wr_en/addr/data word writes;
// cpu_rst held high until a load finishes with a good checksum; done/err report the outcome.
module imem_loader
  import all_pkgs::*;
#(
  parameter int               IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_wr_en,
  output logic [WIDTH-1:0]  imem_wr_addr,
  output logic [WIDTH-1:0]  imem_wr_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);
  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(IMEM_DEPTH);
  loader_state_t     state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic              lenb_q, lenb_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic [WIDTH-1:0]  addr_q, addr_d, wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d, in_ready_q, in_ready_d;
  logic              cpu_rst_q, cpu_rst_d, done_q, done_d, err_q, err_d;
  logic              acc, restart, wv;
  logic [LEN_W-1:0]  n_full;
  logic [WIDTH-1:0]  word;
  assign acc     = in_valid && in_ready_q;
  assign restart = start && state_q inside {IDLE, DONE, ERR};
  assign n_full  = {in_data, len_q[7:0]};
  word_assembler u_wa (
    .clk       (clk),
    .rst       (rst),
    .clr       (restart),
    .en        (acc && state_q == DATA),
    .in_data   (in_data),
    .word_valid(wv),
    .word      (word)
  );
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    lenb_d    = lenb_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    // address advances after each write so it always points at the next word
    addr_d    = wr_en_q ? addr_q + WIDTH'(BYTES_PER_WORD) : addr_q;
    wr_en_d   = wv;
    wr_data_d = wv ? word : wr_data_q;
    if (restart) begin
      state_d = LEN;
      len_d   = '0;
      lenb_d  = 1'b0;
      cnt_d   = '0;
      csum_d  = '0;
      addr_d  = BASE_ADDR;
    end else if (acc) begin
      csum_d = csum_q ^ in_data;
      case (state_q)
        LEN: begin
          lenb_d = 1'b1;
          len_d  = lenb_q ? n_full : {8'd0, in_data};
          if (lenb_q)
            state_d = {1'b0, n_full} > DEPTH_L ? ERR : n_full == '0 ? CHK : DATA;
        end
        DATA: begin
          cnt_d   = wv ? cnt_q + 1'b1 : cnt_q;
          state_d = wv && cnt_q + 1'b1 == len_q ? CHK : DATA;
        end
        CHK:     state_d = csum_q == in_data ? DONE : ERR;
        default: state_d = state_q;
      endcase
    end
    in_ready_d = rx_state(state_d);
    done_d     = state_d == DONE;
    err_d      = state_d == ERR;
    cpu_rst_d  = state_d != DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      lenb_q     <= 1'b0;
      cnt_q      <= '0;
      csum_q     <= '0;
      addr_q     <= BASE_ADDR;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      lenb_q     <= lenb_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= in_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
  assign in_ready     = in_ready_q;
  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = addr_q;
  assign imem_wr_data = wr_data_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err          = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table, directed and random boot streams checked against a stream-level model
module tb_imem_loader;
  localparam int DEPTH = 256;
  logic        clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, imem_wr_en, cpu_rst, done, err;
  logic [31:0] imem_wr_addr, imem_wr_data;
  int          n_chk = 0, n_pass = 0;
  logic [63:0] wq[$];

  typedef struct {
    int         n;
    logic [7:0] ckx;
    int         gap;
    bit         ed;
    bit         ee;
    int         ew;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always @(negedge clk) if (imem_wr_en) wq.push_back({imem_wr_addr, imem_wr_data});

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  function automatic logic [31:0] wgen(int k);
    return 32'h1357_9BDF + 32'(k) * 32'h0101_0103;
  endfunction

  task automatic reset_vals(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 0);
    chk({nm, "_wr_en"}, 32'(imem_wr_en), 0);
    chk({nm, "_wr_addr"}, imem_wr_addr, 0);
    chk({nm, "_wr_data"}, imem_wr_data, 0);
    chk({nm, "_cpu_rst"}, 32'(cpu_rst), 1);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_err"}, 32'(err), 0);
  endtask

  task automatic do_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("start_done", 32'(done), 0);
    chk("start_err", 32'(err), 0);
    chk("start_cpu_rst", 32'(cpu_rst), 1);
    chk("start_in_ready", 32'(in_ready), 1);
  endtask

  // sends nb bytes of s; gap idle cycles before each byte; start pulsed in the gap before byte ms
  task automatic send(input logic [7:0] s[$], input int nb, input int gap, input int ms);
    int t;
    for (int i = 0; i < nb; i++) begin
      in_valid = 0;
      for (int g = 0; g < gap; g++) begin
        start = (i == ms && g == 0);
        @(negedge clk);
      end
      start = 0;
      in_data = s[i];
      in_valid = 1;
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        in_valid = 0;
        chk("handshake_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  // stream model: count LE, words LE, then XOR of every earlier byte (optionally corrupted)
  task automatic make(input int n, input logic [7:0] ckx, input bit rnd,
                      output logic [7:0] s[$], output logic [31:0] w[$]);
    logic [7:0]  x;
    logic [31:0] v;
    s = {};
    w = {};
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    if (n <= DEPTH)
      for (int k = 0; k < n; k++) begin
        v = rnd ? $urandom : wgen(k);
        w.push_back(v);
        for (int b = 0; b < 4; b++) s.push_back(v[8*b+:8]);
      end
    x = 0;
    foreach (s[i]) x ^= s[i];
    if (n <= DEPTH) s.push_back(x ^ ckx);
  endtask

  task automatic check_res(input string nm, input logic [31:0] w[$], input bit ed, input bit ee);
    chk({nm, "_nwr"}, 32'(wq.size()), 32'(w.size()));
    foreach (w[k])
      if (k < wq.size()) begin
        chk({nm, "_addr"}, wq[k][63:32], 32'(4 * k));
        chk({nm, "_data"}, wq[k][31:0], w[k]);
      end
    chk({nm, "_done"}, 32'(done), 32'(ed));
    chk({nm, "_err"}, 32'(err), 32'(ee));
    chk({nm, "_cpu_rst"}, 32'(cpu_rst), 32'(!ed));
    chk({nm, "_in_ready"}, 32'(in_ready), 0);
  endtask

  initial begin
    logic [7:0]  s30[$], s[$];
    logic [31:0] w30[$], w[$];
    int          n, gap, ms;
    logic [7:0]  ckx;
    bit          ed;
    tbl[0] = '{1,   8'h00, 0, 1, 0, 1};
    tbl[1] = '{3,   8'h00, 1, 1, 0, 3};
    tbl[2] = '{4,   8'h5A, 0, 0, 1, 4};
    tbl[3] = '{256, 8'h00, 0, 1, 0, 256};
    tbl[4] = '{257, 8'h00, 0, 0, 1, 0};
    tbl[5] = '{0,   8'h01, 0, 0, 1, 0};
    tbl[6] = '{0,   8'h00, 2, 1, 0, 0};
    s30 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
    w30 = '{32'h0050_0093, 32'h0010_0113};

    repeat (3) @(negedge clk);
    reset_vals("reset");
    rst = 0;

    wq = {}; do_start(); send(s30, 11, 0, -1);
    check_res("basic", w30, 1, 0);

    s = s30; s[10] = 8'hC2;
    wq = {}; do_start(); send(s, 11, 0, -1);
    check_res("bad_csum", w30, 0, 1);

    wq = {}; do_start(); send(s30, 11, 3, 5);
    check_res("gaps_start", w30, 1, 0);

    s = '{8'h00, 8'h00, 8'h00};
    wq = {}; do_start(); send(s, 2, 0, -1);
    chk("empty_pre_done", 32'(done), 0);
    chk("empty_pre_ready", 32'(in_ready), 1);
    s = '{8'h00};
    send(s, 1, 0, -1);
    chk("empty_done", 32'(done), 1);
    chk("empty_cpu_rst", 32'(cpu_rst), 0);
    chk("empty_nwr", 32'(wq.size()), 0);

    s = '{8'h01, 8'h01};
    wq = {}; do_start(); send(s, 2, 0, -1);
    chk("oversize_err", 32'(err), 1);
    chk("oversize_ready", 32'(in_ready), 0);
    chk("oversize_cpu_rst", 32'(cpu_rst), 1);
    chk("oversize_done", 32'(done), 0);
    chk("oversize_nwr", 32'(wq.size()), 0);

    foreach (tbl[i]) begin
      wq = {};
      make(tbl[i].n, tbl[i].ckx, 0, s, w);
      do_start();
      send(s, s.size(), tbl[i].gap, -1);
      chk("tbl_nwr_const", 32'(wq.size()), 32'(tbl[i].ew));
      check_res("tbl", w, tbl[i].ed, tbl[i].ee);
    end

    for (int b = 6; b <= 9; b += 3) begin
      wq = {}; do_start(); send(s30, b, 0, -1);
      rst = 1;
      @(negedge clk) rst = 0;
      reset_vals("midrst");
      chk("midrst_nwr", 32'(wq.size()), 1);
      if (wq.size() > 0) chk("midrst_data", wq[0][31:0], w30[0]);
      wq = {}; do_start(); send(s30, 11, 0, -1);
      check_res("after_rst", w30, 1, 0);
    end

    for (int r = 0; r < 25; r++) begin
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH + 1, 600) : $urandom_range(0, 8);
      ckx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      gap = $urandom_range(0, 2);
      ms = $urandom_range(0, 3 + 4 * 8);
      ed = (n <= DEPTH) && ckx == 0;
      wq = {};
      make(n, ckx, 1, s, w);
      do_start();
      send(s, s.size(), gap, ms);
      check_res("rand", w, ed, !ed);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
